// File: rtl/cmd_bus_arbiter.sv
// cmd_bus_arbiter: shares the chip command bus among NREQ single-beat read/write requesters.
// Build option: define CMD_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module cmd_bus_arbiter #(
   parameter int NREQ   = 4,
   parameter int RD_LAT = 2,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*19-1:0]   req_addr,
   input  logic [NREQ*32-1:0]   req_data,
   output logic [NREQ-1:0]      ack,
   output logic [31:0]          rdata,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic [18:0]          cmd_bus_addr,
   output logic [31:0]          cmd_bus_data,
   output logic                 cmd_bus_en,
   output logic                 cmd_bus_rd,
   output logic                 cmd_bus_wr,
   input  logic [31:0]          cmd_bus_rdata
);

   // state | meaning
   // IDLE  | no transaction; arbitrate when any req is set
   // ISSUE | bus strobes driven for exactly one cycle
   // RWAIT | read latency countdown; capture bus data at zero
   // DONE  | one-cycle ack to the winner
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RWAIT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [1:0]      state;
   logic [CNTW-1:0] cnt;
   logic [IDW-1:0]  win;
   logic            found;

`ifndef CMD_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]  ptr;
   int              idx;

   // Search starts just after the last winner and wraps, so every requester is reached.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[IDW'(idx)]) begin
            win   = IDW'(idx);
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[IDW'(k)]) begin
            win   = IDW'(k);
            found = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         ack          <= '0;
         rdata        <= '0;
         cmd_bus_en   <= 1'b0;
         cmd_bus_rd   <= 1'b0;
         cmd_bus_wr   <= 1'b0;
         cmd_bus_addr <= '0;
         cmd_bus_data <= '0;
`ifndef CMD_ARB_FIXED_PRIO_EN
         ptr          <= IDW'(NREQ-1);
`endif
      end else begin
         ack          <= '0;
         cmd_bus_en   <= 1'b0;
         cmd_bus_rd   <= 1'b0;
         cmd_bus_wr   <= 1'b0;
         cmd_bus_addr <= '0;
         cmd_bus_data <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  // Bus registers double as the latched request for the ISSUE cycle.
                  grant_id     <= win;
                  cmd_bus_en   <= 1'b1;
                  cmd_bus_wr   <= req_wr[win];
                  cmd_bus_rd   <= !req_wr[win];
                  cmd_bus_addr <= req_addr[int'(win)*19 +: 19];
                  cmd_bus_data <= req_data[int'(win)*32 +: 32];
                  busy         <= 1'b1;
                  state        <= S_ISSUE;
`ifndef CMD_ARB_FIXED_PRIO_EN
                  ptr          <= win;
`endif
               end
            end
            S_ISSUE: begin
               if (cmd_bus_wr) begin
                  ack[grant_id] <= 1'b1;
                  state         <= S_DONE;
               end else begin
                  cnt   <= CNTW'(RD_LAT-1);
                  state <= S_RWAIT;
               end
            end
            S_RWAIT: begin
               if (cnt == '0) begin
                  rdata         <= cmd_bus_rdata;
                  ack[grant_id] <= 1'b1;
                  state         <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Self-checking bench for cmd_bus_arbiter: transaction-level reference model with randomized requests.
module tb_cmd_bus_arbiter;
   localparam int NREQ   = 4;
   localparam int RD_LAT = 2;
   localparam int IDW    = $clog2(NREQ);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ-1:0]     req_wr = '0;
   logic [NREQ*19-1:0]  req_addr = '0;
   logic [NREQ*32-1:0]  req_data = '0;
   logic [NREQ-1:0]     ack;
   logic [31:0]         rdata;
   logic [IDW-1:0]      grant_id;
   logic                busy;
   logic [18:0]         cmd_bus_addr;
   logic [31:0]         cmd_bus_data;
   logic                cmd_bus_en;
   logic                cmd_bus_rd;
   logic                cmd_bus_wr;
   logic [31:0]         cmd_bus_rdata = '0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ptr     = NREQ-1;
   logic [31:0] model_rdata = '0;

   cmd_bus_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_data(req_data), .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
      .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data), .cmd_bus_en(cmd_bus_en),
      .cmd_bus_rd(cmd_bus_rd), .cmd_bus_wr(cmd_bus_wr), .cmd_bus_rdata(cmd_bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin: first pending requester after the last winner, with wrap.
   function automatic int pick(input logic [NREQ-1:0] p);
`ifdef CMD_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (p[i]) return i;
`else
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (ptr + k) % NREQ;
         if (p[j]) return j;
      end
`endif
      return -1;
   endfunction

   task automatic set_req(input int i, input logic wr, input logic [18:0] a, input logic [31:0] d);
      req_wr[i]            = wr;
      req_addr[19*i +: 19] = a;
      req_data[32*i +: 32] = d;
      req[i]               = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ack"},   ack, 0);
      check_eq({tag, "_rdata"}, rdata, 0);
      check_eq({tag, "_gid"},   grant_id, 0);
      check_eq({tag, "_busy"},  busy, 0);
      check_eq({tag, "_strb"},  {cmd_bus_en, cmd_bus_rd, cmd_bus_wr}, 0);
      check_eq({tag, "_addr"},  cmd_bus_addr, 0);
      check_eq({tag, "_data"},  cmd_bus_data, 0);
   endtask

   // Called just after the negedge of an IDLE cycle; returns after the negedge of the next IDLE cycle.
   task automatic run_txn();
      int          w;
      logic        wr;
      logic [18:0] a;
      logic [31:0] d;
      check_eq("idle_busy", busy, 0);
      if (req == '0) begin
         @(negedge clk);
         check_eq("quiet_strb", {cmd_bus_en, cmd_bus_rd, cmd_bus_wr}, 0);
         check_eq("quiet_addr", cmd_bus_addr, 0);
         check_eq("quiet_data", cmd_bus_data, 0);
         check_eq("quiet_ack",  ack, 0);
         return;
      end
      w   = pick(req);
      ptr = w;
      wr  = req_wr[w];
      a   = req_addr[19*w +: 19];
      d   = req_data[32*w +: 32];
      @(negedge clk);
      cmd_bus_rdata = $urandom;
      check_eq("iss_en",   cmd_bus_en, 1);
      check_eq("iss_wr",   cmd_bus_wr, wr);
      check_eq("iss_rd",   cmd_bus_rd, !wr);
      check_eq("iss_addr", cmd_bus_addr, a);
      check_eq("iss_data", cmd_bus_data, d);
      check_eq("iss_gid",  grant_id, w);
      check_eq("iss_busy", busy, 1);
      check_eq("iss_ack",  ack, 0);
      if (!wr) begin
         for (int c = 2; c <= 1 + RD_LAT; c++) begin
            @(negedge clk);
            cmd_bus_rdata = $urandom;
            if (c == 1 + RD_LAT) model_rdata = cmd_bus_rdata;
            check_eq("rw_en",   cmd_bus_en, 0);
            check_eq("rw_ack",  ack, 0);
            check_eq("rw_busy", busy, 1);
         end
      end
      @(negedge clk);
      cmd_bus_rdata = $urandom;
      check_eq("done_ack",   ack, 64'(1) << w);
      check_eq("done_rdata", rdata, model_rdata);
      check_eq("done_busy",  busy, 1);
      check_eq("done_strb",  {cmd_bus_en, cmd_bus_rd, cmd_bus_wr}, 0);
      req[w] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      set_req(2, 1'b1, 19'h00012, 32'hDEADBEEF);
      run_txn();
      set_req(1, 1'b0, 19'h7FFFF, 32'h0);
      run_txn();

      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom_range(0, 1)), 19'($urandom), $urandom);
      repeat (5) begin
         run_txn();
         req = '1;
      end
      req = '0;

      set_req(0, 1'b1, 19'h00100, 32'h11112222);
      run_txn();
      req[0] = 1'b1;
      set_req(3, 1'b0, 19'h00300, 32'h0);
      run_txn();
`ifndef CMD_ARB_FIXED_PRIO_EN
      check_eq("b2b_second_gid", grant_id, 3);
`endif
      run_txn();

      repeat (100) run_txn();

      // Abort a read in its first RWAIT cycle.
      set_req(1, 1'b0, 19'h0ABCD, 32'h0);
      ptr = pick(req);
      @(negedge clk);
      check_eq("rst_pre_en", cmd_bus_en, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_all_zero("midrst");
      set_req(0, 1'b1, 19'h01234, 32'h55AA55AA);
      repeat (3) begin
         @(negedge clk);
         check_eq("midrst_noack", ack, 0);
      end
      rst = 1'b0;
      ptr = NREQ-1;
      model_rdata = '0;
      run_txn();
      check_eq("post_rst_gid", grant_id, 0);
      run_txn();

      repeat (300) begin
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1'($urandom_range(0, 1)), 19'($urandom), $urandom);
         run_txn();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
